// File: rtl/config_streamer_pkg.sv
// config_streamer_pkg: shared state encoding and counter width helper for the config streamer
package config_streamer_pkg;
  typedef enum logic [2:0] {CS_IDLE, CS_CLEAR, CS_WAIT, CS_SHIFT, CS_DONE} cs_state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/config_word_serializer.sv
// config_word_serializer: parallel-in serial-out word shifter, MSB first, with per-word bit count
module config_word_serializer
  import config_streamer_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  next_bit,
  output logic                  last
);
  localparam int CW = cnt_width(WORD_WIDTH);
  logic [WORD_WIDTH-1:0] sr, sr_sh;
  logic [CW-1:0] word_bit_cnt;
  always_comb begin
    sr_sh = sr << 1;
    next_bit = load ? data[WORD_WIDTH-1] : sr_sh[WORD_WIDTH-1];
    last = word_bit_cnt == CW'(WORD_WIDTH - 1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sr <= '0;
      word_bit_cnt <= '0;
    end else if (load) begin
      sr <= data;
      word_bit_cnt <= '0;
    end else if (shift) begin
      sr <= sr_sh;
      word_bit_cnt <= word_bit_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/config_streamer.sv
// config_streamer: clears the config chain, then shifts host words into it MSB-first and checks the return bit
module config_streamer
  import config_streamer_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_BITS   = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data,
  output logic                  config_enable,
  output logic                  config_nreset,
  input  logic                  config_return,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int BW  = cnt_width(CHAIN_BITS);
  localparam int CCW = cnt_width(CLEAR_CYCLES);
  cs_state_t state, nxt;
  logic [BW-1:0] bit_cnt;
  logic [CCW-1:0] clr_cnt;
  logic load, shift, next_bit, last;
  config_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .data    (word_data),
    .next_bit(next_bit),
    .last    (last)
  );
  always_comb begin
    nxt = state;
    case (state)
      CS_IDLE:  nxt = start ? CS_CLEAR : CS_IDLE;
      CS_CLEAR: nxt = clr_cnt == CCW'(CLEAR_CYCLES - 1) ? CS_WAIT : CS_CLEAR;
      CS_WAIT:  nxt = word_valid ? CS_SHIFT : CS_WAIT;
      CS_SHIFT: nxt = bit_cnt == BW'(CHAIN_BITS - 1) ? CS_DONE : last ? CS_WAIT : CS_SHIFT;
      CS_DONE:  nxt = CS_IDLE;
      default:  nxt = CS_IDLE;
    endcase
    word_ready = state == CS_WAIT;
    load = word_ready && word_valid;
    shift = state == CS_SHIFT;
    config_nreset = state != CS_CLEAR;
    busy = state != CS_IDLE;
    done = state == CS_DONE;
  end
  // config_data/config_enable are flopped from the next state so they line up with the SHIFT cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CS_IDLE;
      clr_cnt <= '0;
      bit_cnt <= '0;
      error <= 1'b0;
      config_data <= 1'b0;
      config_enable <= 1'b0;
    end else begin
      state <= nxt;
      config_enable <= nxt == CS_SHIFT;
      config_data <= nxt == CS_SHIFT && next_bit;
      clr_cnt <= state == CS_CLEAR ? clr_cnt + CCW'(1) : '0;
      bit_cnt <= shift ? bit_cnt + BW'(1) : busy ? bit_cnt : '0;
      if (state == CS_IDLE && start)
        error <= 1'b0;
      else if (shift && config_return)
        error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_config_streamer.sv
// tb_config_streamer: randomized scoreboard bench for config_streamer plus a 16-bit chain boundary case
module tb_config_streamer;
  localparam int W = 8, CB = 20, CC = 2, CB2 = 16;
  logic clock = 0, reset = 1, start = 0, word_valid = 0, config_return = 0;
  logic [W-1:0] word_data = '0;
  logic word_ready, config_data, config_enable, config_nreset, busy, done, error;
  logic start2 = 0, word_valid2 = 0, config_return2 = 0;
  logic [W-1:0] word_data2 = '0;
  logic word_ready2, config_data2, config_enable2, config_nreset2, busy2, done2, error2;
  int vectors = 0, miscompares = 0;
  bit exp_q[$];
  int pushed = 0, en_n = 0, nr_n = 0, done_n = 0, ret_at = 0;
  bit exp_err = 0;
  logic nrst_prev = 1;
  config_streamer #(.WORD_WIDTH(W), .CHAIN_BITS(CB), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .start(start), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .config_data(config_data), .config_enable(config_enable),
    .config_nreset(config_nreset), .config_return(config_return), .busy(busy), .done(done), .error(error)
  );
  config_streamer #(.WORD_WIDTH(W), .CHAIN_BITS(CB2), .CLEAR_CYCLES(CC)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .word_data(word_data2), .word_valid(word_valid2),
    .word_ready(word_ready2), .config_data(config_data2), .config_enable(config_enable2),
    .config_nreset(config_nreset2), .config_return(config_return2), .busy(busy2), .done(done2), .error(error2)
  );
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  // reference: the chain receives the host words' bits MSB-first, truncated at CB bits
  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--)
      if (pushed < CB) begin
        exp_q.push_back(w[i]);
        pushed++;
      end
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      if (!config_nreset) begin
        if (nrst_prev) begin
          en_n = 0;
          nr_n = 0;
        end
        nr_n++;
        check("enable_in_clear", {31'b0, config_enable}, 0);
      end
      if (config_enable) begin
        en_n++;
        if (exp_q.size() == 0)
          check("extra_bit", 1, 0);
        else
          check($sformatf("bit%0d", en_n), {31'b0, config_data}, {31'b0, exp_q.pop_front()});
        config_return = en_n == ret_at;
        if (config_return)
          exp_err = 1;
      end else
        config_return = 0;
      if (done) begin
        done_n++;
        check("enable_count", en_n, CB);
        check("clear_cycles", nr_n, CC);
        check("error_at_done", {31'b0, error}, {31'b0, exp_err});
        check("leftover_bits", exp_q.size(), 0);
      end
    end
    nrst_prev = config_nreset;
  end
  task automatic send_word(input logic [W-1:0] w, input int gap);
    int t = 0;
    @(negedge clock);
    while (!word_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) begin
      check("ready_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < gap; i++) begin
      check("enable_during_gap", {31'b0, config_enable}, 0);
      @(negedge clock);
    end
    push_word(w);
    word_data = w;
    word_valid = 1;
    @(posedge clock);
    #1 word_valid = 0;
  endtask
  task automatic begin_load(input int ret);
    ret_at = ret;
    pushed = 0;
    exp_q.delete();
    exp_err = 0;
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    check("error_cleared_on_start", {31'b0, error}, 0);
  endtask
  task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                          input int g1, input int ret, input bit spur);
    int d0 = done_n;
    begin_load(ret);
    if (spur)
      fork
        begin
          int t = 0;
          do begin @(negedge clock); #1; t++; end while (!(config_enable && en_n == 5) && t < 200);
          start = 1;
          @(negedge clock);
          #1 start = 0;
          t = 0;
          do begin @(negedge clock); #1; t++; end while (!done && t < 200);
          start = 1;
          @(negedge clock);
          #1 start = 0;
        end
      join_none
    send_word(w0, 0);
    send_word(w1, g1);
    send_word(w2, 0);
    for (int t = 0; t < 100 && done_n == d0; t++) begin
      @(negedge clock);
      #1;
    end
    repeat (6) @(negedge clock);
    check("done_pulses", done_n - d0, 1);
    check("idle_after_load", {31'b0, busy}, 0);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    check("rst_word_ready", {31'b0, word_ready}, 0);
    check("rst_config_data", {31'b0, config_data}, 0);
    check("rst_config_enable", {31'b0, config_enable}, 0);
    check("rst_config_nreset", {31'b0, config_nreset}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_error", {31'b0, error}, 0);
    reset = 0;
    run_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0);
    run_load(8'hA5, 8'h3C, 8'hF0, 5, 0, 0);
    run_load(8'hA5, 8'h3C, 8'hF0, 0, 7, 0);
    run_load(8'h5A, 8'hC3, 8'h0F, 0, 0, 0);
    begin_load(0);
    send_word(8'h96, 0);
    send_word(8'h69, 0);
    begin
      int t = 0;
      do begin @(negedge clock); #1; t++; end while (!(config_enable && en_n == 10) && t < 100);
      check("abort_point_reached", en_n, 10);
    end
    reset = 1;
    @(posedge clock);
    #1;
    check("abort_enable", {31'b0, config_enable}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_ready", {31'b0, word_ready}, 0);
    check("abort_nreset", {31'b0, config_nreset}, 1);
    @(negedge clock);
    reset = 0;
    exp_q.delete();
    run_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0);
    run_load(8'h81, 8'h7E, 8'hC9, 0, 0, 1);
    for (int r = 0; r < 8; r++)
      run_load(W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 1) ? $urandom_range(1, CB) : 0, 1'($urandom_range(0, 1)));
    begin
      logic [15:0] got2 = '0;
      int en2n = 0, d2n = 0, acc = 0;
      bit hs;
      @(negedge clock);
      start2 = 1;
      @(negedge clock);
      start2 = 0;
      word_data2 = 8'hFF;
      word_valid2 = 1;
      for (int t = 0; t < 60; t++) begin
        @(negedge clock);
        if (config_enable2) begin
          got2 = {got2[14:0], config_data2};
          en2n++;
        end
        if (done2) d2n++;
        hs = word_ready2 && word_valid2;
        @(posedge clock);
        #1;
        if (hs) begin
          acc++;
          word_data2 = 8'h00;
        end
      end
      check("c16_enable_count", en2n, CB2);
      check("c16_stream", {16'b0, got2}, 32'h0000FF00);
      check("c16_done_pulses", d2n, 1);
      check("c16_words_accepted", acc, 2);
      check("c16_ready_after", {31'b0, word_ready2}, 0);
      check("c16_busy_after", {31'b0, busy2}, 0);
      word_valid2 = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
